fir_tf_param: RTL

// - Parametrised transposed-form FIR: TAPS signed coefficients, sample-valid qualified, registered output.
// - Coefficients are written into a shadow bank and committed atomically; filtering continues during writes.
// - Output stage rounds, scales and saturates.
// - Sits between the sample source and downstream DSP.

---
 rtl/fir_tf_param.sv | 107 ++++++++++
 1 files changed

// File: rtl/fir_tf_param.sv
// Transposed-form FIR with shadow/active coefficient banks, round/scale/saturate output register.
// One cycle from x_valid to y_valid; no backpressure, every x_valid sample is accepted unless clear is high.
module fir_tf_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  input  logic                     x_valid,
  input  logic signed [DATA_W-1:0] x,
  output logic                     y_valid,
  output logic signed [OUT_W-1:0]  y,
  output logic                     y_sat
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int AW    = $clog2(TAPS);
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((64'sd1 <<< SHIFT) >>> 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic signed [COEF_W-1:0] r_ca [TAPS];
  logic signed [COEF_W-1:0] r_sh [TAPS];
  logic signed [ACC_W-1:0]  r_p  [TAPS-1];
  logic                     r_y_vld;
  logic signed [OUT_W-1:0]  r_y;
  logic                     r_y_sat;

  logic signed [ACC_W-1:0]  w_prod [TAPS];
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_r;
  logic signed [OUT_W-1:0]  w_y;
  logic                     w_sat;
  logic                     w_addr_ok;

  if ((1 << AW) == TAPS) begin : g_pow2
    assign w_addr_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [AW:0] TAPS_L = (AW+1)'(TAPS);
    assign w_addr_ok = ({1'b0, coef_addr} < TAPS_L);
  end

  // Operands are sign-extended to ACC_W first, so the truncated product is exact.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_prod[k] = ACC_W'(r_ca[k]) * ACC_W'(x);
    end
  end

  always_comb begin
    w_acc = r_p[0] + w_prod[0];
    w_rnd = (ACC_W+1)'(w_acc) + RND;
    w_r   = w_rnd >>> SHIFT;
    w_y   = w_r[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_r > MAXV) begin
      w_y   = MAXV[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_r < MINV) begin
      w_y   = MINV[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_ca[k] <= '0;
        r_sh[k] <= '0;
      end
      for (int j = 0; j < TAPS-1; j++) r_p[j] <= '0;
      r_y_vld <= 1'b0;
      r_y     <= '0;
      r_y_sat <= 1'b0;
    end else begin
      r_y_vld <= 1'b0;
      // Commit reads the pre-write shadow because both updates are non-blocking.
      if (coef_we && w_addr_ok) r_sh[coef_addr] <= coef_wdata;
      if (coef_commit) begin
        for (int k = 0; k < TAPS; k++) r_ca[k] <= r_sh[k];
      end
      if (clear) begin
        for (int j = 0; j < TAPS-1; j++) r_p[j] <= '0;
      end else if (x_valid) begin
        for (int j = 0; j < TAPS-2; j++) r_p[j] <= r_p[j+1] + w_prod[j+1];
        r_p[TAPS-2] <= w_prod[TAPS-1];
        r_y_vld     <= 1'b1;
        r_y         <= w_y;
        r_y_sat     <= w_sat;
      end
    end
  end

  assign y_valid = r_y_vld;
  assign y       = r_y;
  assign y_sat   = r_y_sat;

endmodule
